// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder, data-phase response mux and built-in default
// slave. Unmapped active transfers get the two-cycle ERROR response and are
// counted in a saturating 8-bit counter.
module ahb_decoder_mux #(
  parameter int NUM_SLAVES  = 10,
  parameter int REGION_BITS = 8,
  parameter logic [NUM_SLAVES*REGION_BITS-1:0] BASE_LIST =
    {8'h58, 8'h57, 8'h56, 8'h55, 8'h54, 8'h53, 8'h52, 8'h51, 8'h50, 8'h00}
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  output logic [NUM_SLAVES-1:0]      HSEL,
  output logic                       HSEL_NOMAP,
  input  logic [NUM_SLAVES*32-1:0]   HRDATA_S,
  input  logic [NUM_SLAVES-1:0]      HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]      HRESP_S,
  output logic [31:0]                HRDATA,
  output logic                       HREADY,
  output logic                       HRESP,
  input  logic                       ERR_CLR,
  output logic [7:0]                 ERR_CNT
);

  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] SEL_NONE = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} dft_state_e;

  logic [NUM_SLAVES-1:0] match;
  logic [SEL_W-1:0]      sel_enc, sel_q;
  dft_state_e            state_q, state_d;
  logic                  dft_ready, dft_resp, err_start, err_go;
  logic [7:0]            cnt_q, cnt_d;
  logic                  unused_bits;

  // Only the region tag bits and HTRANS[1] matter to the decoder.
  assign unused_bits = ^{HADDR[31-REGION_BITS:0], HTRANS[0]};

  // One tag comparator per mapped region.
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_cmp
    assign match[g] = (HADDR[31 -: REGION_BITS] == BASE_LIST[g*REGION_BITS +: REGION_BITS]);
  end

  // Priority decode: scan high to low so the lowest matching index wins.
  always_comb begin
    HSEL    = '0;
    sel_enc = SEL_NONE;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        HSEL    = NUM_SLAVES'(1) << i;
        sel_enc = SEL_W'(i);
      end
    end
  end

  assign HSEL_NOMAP = ~|match;

  // Data-phase select follows the address phase whenever the bus is ready.
  always_ff @(posedge HCLK) begin
    if (HRESET)     sel_q <= SEL_NONE;
    else if (HREADY) sel_q <= sel_enc;
  end

  // Response mux; any select outside the slave range falls to the default slave.
  always_comb begin
    HRDATA = '0;
    HREADY = dft_ready;
    HRESP  = dft_resp;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        HRDATA = HRDATA_S[i*32 +: 32];
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[i];
      end
    end
  end

  assign err_start = HREADY & HSEL_NOMAP & HTRANS[1];

  // Default slave state register.
  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Default slave next state: an unmapped active transfer opens a 2-cycle ERROR.
  always_comb begin
    state_d = S_IDLE;
    unique case (state_q)
      S_IDLE:  state_d = err_start ? S_ERR1 : S_IDLE;
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = err_start ? S_ERR1 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Default slave outputs: stall in the first ERROR cycle, release in the second.
  always_comb begin
    dft_ready = 1'b1;
    dft_resp  = 1'b0;
    unique case (state_q)
      S_ERR1:  begin dft_ready = 1'b0; dft_resp = 1'b1; end
      S_ERR2:  begin dft_ready = 1'b1; dft_resp = 1'b1; end
      default: begin dft_ready = 1'b1; dft_resp = 1'b0; end
    endcase
  end

  // A new error is each entry into ERR1; clear beats increment.
  assign err_go = (state_q != S_ERR1) & err_start;

  always_comb begin
    cnt_d = cnt_q;
    if (ERR_CLR)                     cnt_d = '0;
    else if (err_go && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  // Saturating error counter.
  always_ff @(posedge HCLK) begin
    if (HRESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ERR_CNT = cnt_q;

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Bench for ahb_decoder_mux: a transaction-level bus model is compared
// against the DUT every cycle, plus directed literal checks.
module tb_ahb_decoder_mux;

  localparam int NS = 10;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic [NS-1:0]     HSEL;
  logic              HSEL_NOMAP;
  logic [NS*32-1:0]  HRDATA_S;
  logic [NS-1:0]     HREADYOUT_S;
  logic [NS-1:0]     HRESP_S;
  logic [31:0]       HRDATA;
  logic              HREADY;
  logic              HRESP;
  logic              ERR_CLR;
  logic [7:0]        ERR_CNT;

  ahb_decoder_mux dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL(HSEL), .HSEL_NOMAP(HSEL_NOMAP), .HRDATA_S(HRDATA_S),
    .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .ERR_CLR(ERR_CLR), .ERR_CNT(ERR_CNT)
  );

  always #5 HCLK = ~HCLK;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Memory map as a plain table: index = slave, value = HADDR[31:24].
  int tags [NS] = '{8'h00, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58};

  // Model state: who owns the data phase (-1 = default slave), which
  // ERROR cycle we are in (0 none, 1 first, 2 second), and the error count.
  int m_owner = -1;
  int m_phase = 0;
  int m_cnt   = 0;

  function automatic int decode(logic [31:0] a);
    for (int i = 0; i < NS; i++) if (int'(a[31:24]) == tags[i]) return i;
    return -1;
  endfunction

  function automatic logic m_ready();
    if (m_owner >= 0) return HREADYOUT_S[m_owner];
    return m_phase != 1;
  endfunction

  function automatic logic m_resp();
    if (m_owner >= 0) return HRESP_S[m_owner];
    return m_phase != 0;
  endfunction

  function automatic logic [31:0] m_rdata();
    if (m_owner >= 0) return HRDATA_S[m_owner*32 +: 32];
    return 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model on each edge with the inputs the DUT also sees.
  always @(posedge HCLK) begin
    if (HRESET) begin
      m_owner = -1; m_phase = 0; m_cnt = 0;
    end else begin
      automatic logic rdy = m_ready();
      automatic int   d   = decode(HADDR);
      automatic bit   new_err = (m_phase != 1) && rdy && d < 0 && HTRANS[1];
      if (ERR_CLR)                   m_cnt = 0;
      else if (new_err && m_cnt < 255) m_cnt++;
      m_phase = (m_phase == 1) ? 2 : (new_err ? 1 : 0);
      if (rdy) m_owner = d;
    end
  end

  // Per-cycle compare against the model, mid-cycle.
  always @(negedge HCLK) begin
    if (chk_en) begin
      automatic int d = decode(HADDR);
      automatic logic [NS-1:0] exp_sel = (d >= 0) ? (NS'(1) << d) : '0;
      chk("m_hsel",   32'(HSEL),       32'(exp_sel));
      chk("m_nomap",  32'(HSEL_NOMAP), 32'(d < 0));
      chk("m_hready", 32'(HREADY),     32'(m_ready()));
      chk("m_hresp",  32'(HRESP),      32'(m_resp()));
      chk("m_hrdata", HRDATA,          m_rdata());
      chk("m_errcnt", 32'(ERR_CNT),    32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge HCLK); #1;
  endtask

  task automatic sample();
    @(negedge HCLK); #1;
  endtask

  initial begin
    HRESET = 1'b1; HADDR = 32'h0; HTRANS = 2'b00; ERR_CLR = 1'b0;
    HREADYOUT_S = '1; HRESP_S = '0;
    for (int i = 0; i < NS; i++) HRDATA_S[i*32 +: 32] = 32'hD000_0000 + 32'(i);
    HRDATA_S[4*32 +: 32] = 32'hCAFE_F00D;

    // Reset state
    step(); chk_en = 1'b1;
    sample();
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp",  32'(HRESP),  32'd0);
    chk("rst_hrdata", HRDATA,      32'h0);
    chk("rst_errcnt", 32'(ERR_CNT), 32'd0);
    step(); HRESET = 1'b0;
    step();

    // Mapped read from slave 4
    HADDR = 32'h5300_0010; HTRANS = 2'b10;
    sample(); chk("s4_hsel", 32'(HSEL), 32'h010);
    step(); HADDR = 32'h7000_0000; HTRANS = 2'b00;
    sample(); chk("s4_rdata", HRDATA, 32'hCAFE_F00D);
    step();
    sample(); chk("idle_nomap_okay", 32'({HREADY, HRESP}), 32'b10);

    // Slave 1 stalls three cycles with the next address pending
    HADDR = 32'h5000_0000; HTRANS = 2'b10;
    step(); HREADYOUT_S[1] = 1'b0; HADDR = 32'h0000_0100;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("stall_rdata",  HRDATA,        32'hD000_0001);
      chk("stall_hready", 32'(HREADY),   32'd0);
      step();
    end
    HREADYOUT_S[1] = 1'b1;
    sample(); chk("stall_release", HRDATA, 32'hD000_0001);
    step(); HTRANS = 2'b00;
    sample(); chk("after_stall_s0", HRDATA, 32'hD000_0000);
    step();

    // Single unmapped error
    HADDR = 32'h7000_0000; HTRANS = 2'b10;
    sample(); chk("err_nomap", 32'({HSEL_NOMAP, HSEL}), 32'h400);
    step(); HTRANS = 2'b00;
    sample(); chk("err_cyc1", 32'({HREADY, HRESP}), 32'b01);
    step();
    sample(); chk("err_cyc2", 32'({HREADY, HRESP}), 32'b11);
    step();
    sample(); chk("err_done", 32'({HREADY, HRESP}), 32'b10);
    chk("err_cnt1", 32'(ERR_CNT), 32'd1);

    // Back-to-back errors to 0xFF00_0000, count from zero
    ERR_CLR = 1'b1; step(); ERR_CLR = 1'b0;
    HADDR = 32'hFF00_0000; HTRANS = 2'b10;
    step();
    sample(); chk("b2b_e1a", 32'({HREADY, HRESP}), 32'b01);
    step();
    sample(); chk("b2b_e2a", 32'({HREADY, HRESP}), 32'b11);
    step(); HTRANS = 2'b00;
    sample(); chk("b2b_e1b", 32'({HREADY, HRESP}), 32'b01);
    step();
    sample(); chk("b2b_e2b", 32'({HREADY, HRESP}), 32'b11);
    step();
    sample(); chk("b2b_idle", 32'({HREADY, HRESP}), 32'b10);
    chk("b2b_cnt", 32'(ERR_CNT), 32'd2);
    step();
    sample(); chk("idle_no_count", 32'(ERR_CNT), 32'd2);

    // Saturation: 260 continuous errors
    HTRANS = 2'b10;
    for (int k = 0; k < 520; k++) step();
    sample(); chk("sat_cnt", 32'(ERR_CNT), 32'hFF);
    ERR_CLR = 1'b1;
    step(); ERR_CLR = 1'b0;
    sample();
    chk("clr_wins", 32'(ERR_CNT), 32'd0);
    chk("clr_in_err1", 32'({HREADY, HRESP}), 32'b01);

    // Reset in the middle of an ERROR
    HRESET = 1'b1; HTRANS = 2'b00;
    step();
    sample(); chk("rst_mid_err", 32'({HREADY, HRESP}), 32'b10);
    HRESET = 1'b0;
    step(); step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
